// File: rtl/eproc_in_frame_assembler.sv
// E-link receive frame assembler: delimits frames, packs bytes into 16-bit FIFO words.
// Optional statistics counters are enabled with `define FRAME_STATS_EN.
module eproc_in_frame_assembler #(
    parameter int unsigned MAX_LEN = 1024
) (
    input  logic        bitCLK,
    input  logic        rst,
    input  logic [9:0]  DATA_IN,
    input  logic        DATA_RDY,
    input  logic        fifo_full,
    output logic        wr_en,
    output logic [15:0] dout,
    output logic [1:0]  dout_ben,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic        dout_err,
    output logic        overflow,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, IN_FRAME, DROP} state_t;

    localparam logic [1:0]  K_DATA  = 2'b00;
    localparam logic [1:0]  K_EOP   = 2'b01;
    localparam logic [1:0]  K_SOP   = 2'b10;
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    state_t      state, state_n;
    logic [7:0]  hold, hold_n;
    logic        ptr, ptr_n;
    logic [15:0] len, len_n;
    logic        first, first_n;

    logic [1:0]  kind;
    logic [7:0]  sym;
    logic        wr_req, close, restart, frame_inc, err_inc;
    logic [15:0] w_data;
    logic [1:0]  w_ben;
    logic        w_sop, w_eop, w_err;

    assign kind = DATA_IN[9:8];
    assign sym  = DATA_IN[7:0];

    always_comb begin
        state_n   = state;
        hold_n    = hold;
        ptr_n     = ptr;
        len_n     = len;
        first_n   = first;
        wr_req    = 1'b0;
        close     = 1'b0;
        restart   = 1'b0;
        frame_inc = 1'b0;
        err_inc   = 1'b0;
        w_data    = '0;
        w_ben     = '0;
        w_sop     = 1'b0;
        w_eop     = 1'b0;
        w_err     = 1'b0;

        if (DATA_RDY) begin
            unique case (state)
                IDLE: begin
                    if (kind == K_SOP)
                        restart = 1'b1;
                    else if (kind == K_DATA || kind == K_EOP)
                        err_inc = 1'b1;
                end
                IN_FRAME: begin
                    case (kind)
                        K_DATA: begin
                            if (len < MAX_LEN_W) begin
                                len_n = len + 16'd1;
                                if (!ptr) begin
                                    hold_n = sym;
                                    ptr_n  = 1'b1;
                                end else begin
                                    wr_req  = 1'b1;
                                    w_data  = {sym, hold};
                                    w_ben   = 2'b11;
                                    w_sop   = first;
                                    first_n = 1'b0;
                                    ptr_n   = 1'b0;
                                end
                            end else begin
                                close   = 1'b1;
                                w_err   = 1'b1;
                                err_inc = 1'b1;
                                state_n = DROP;
                            end
                        end
                        K_EOP: begin
                            close     = 1'b1;
                            frame_inc = 1'b1;
                            state_n   = IDLE;
                        end
                        K_SOP: begin
                            close   = 1'b1;
                            w_err   = 1'b1;
                            err_inc = 1'b1;
                            restart = 1'b1;
                        end
                        default: ;
                    endcase
                end
                DROP: begin
                    if (kind == K_EOP)
                        state_n = IDLE;
                    else if (kind == K_SOP)
                        restart = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end

        // Closing word: flush a pending odd byte, otherwise an empty marker word.
        if (close) begin
            wr_req = 1'b1;
            w_eop  = 1'b1;
            w_sop  = first;
            w_data = {8'h00, ptr ? hold : 8'h00};
            w_ben  = {1'b0, ptr};
        end
        if (restart) begin
            state_n = IN_FRAME;
            ptr_n   = 1'b0;
            len_n   = '0;
            first_n = 1'b1;
        end
        // A lost mid-frame word poisons the rest of the frame.
        if (wr_req && fifo_full && !close) begin
            err_inc = 1'b1;
            state_n = DROP;
        end
    end

    always_ff @(posedge bitCLK) begin
        if (rst) begin
            state    <= IDLE;
            hold     <= '0;
            ptr      <= 1'b0;
            len      <= '0;
            first    <= 1'b0;
            wr_en    <= 1'b0;
            dout     <= '0;
            dout_ben <= '0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            dout_err <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            hold  <= hold_n;
            ptr   <= ptr_n;
            len   <= len_n;
            first <= first_n;
            wr_en <= wr_req && !fifo_full;
            if (wr_req && !fifo_full) begin
                dout     <= w_data;
                dout_ben <= w_ben;
                dout_sop <= w_sop;
                dout_eop <= w_eop;
                dout_err <= w_err;
            end
            if (wr_req && fifo_full)
                overflow <= 1'b1;
        end
    end

`ifdef FRAME_STATS_EN
    always_ff @(posedge bitCLK) begin
        if (rst) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (frame_inc && frame_cnt != 16'hFFFF)
                frame_cnt <= frame_cnt + 16'd1;
            if (err_inc && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end
`else
    logic stats_unused;
    assign stats_unused = frame_inc ^ err_inc;
    assign frame_cnt    = '0;
    assign err_cnt      = '0;
`endif

endmodule
